// File: rtl/tag_store.sv
// tag_store: per-bank valid/dirty/tag array of the cache.
// Combinational read by line index; fills and dirty-marking writes update
// the array on the rising clock edge. Synchronous active-high reset.
// Optional macro TAG_STORE_DBG_PRINT_EN enables a simulation trace of every
// fill and write; behaviour is identical with or without it.
module tag_store #(
    parameter int CACHE_SIZE       = 16384,
    parameter int CACHE_LINE_SIZE  = 64,
    parameter int NUM_BANKS        = 4,
    parameter int WORD_SIZE        = 4,
    parameter int BANK_ADDR_OFFSET = 0,
    localparam int unsigned LINES  = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
    localparam int unsigned LSB    = $clog2(LINES),
    localparam int unsigned LAW    = 32 - $clog2(CACHE_LINE_SIZE) - $clog2(NUM_BANKS),
    localparam int unsigned TSB    = LAW - LSB
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [LSB-1:0] raddr,
    output logic           read_valid,
    output logic           read_dirty,
    output logic [TSB-1:0] read_tag,
    input  logic           do_fill,
    input  logic [TSB-1:0] fill_tag,
    input  logic [LSB-1:0] waddr,
    input  logic           do_write
);

    // Reject configurations the array cannot represent.
    if (LINES < 2 || WORD_SIZE < 1 || BANK_ADDR_OFFSET < 0) begin : g_param_err
        $error("tag_store: invalid parameter set");
    end

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TSB-1:0]   tag_q [LINES];
    logic [TSB-1:0]   tag_d [LINES];

    // Read path; reset forces zeros so outputs are clean during reset too.
    assign read_valid = !reset && valid_q[raddr];
    assign read_dirty = !reset && dirty_q[raddr];
    assign read_tag   = reset ? '0 : tag_q[raddr];

    // Next state: fill first, then write, so a same-index write leaves dirty set.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (do_fill) begin
            valid_d[raddr] = 1'b1;
            dirty_d[raddr] = 1'b0;
            tag_d[raddr]   = fill_tag;
        end
        if (do_write) begin
            dirty_d[waddr] = 1'b1;
        end
    end

    // State register; reset wins over any update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
        end
    end

`ifdef TAG_STORE_DBG_PRINT_EN
    // Simulation trace of updates accepted this cycle.
    always @(posedge clk) begin
        if (!reset) begin
            if (do_fill)
                $display("%0t tag_store fill  idx=%0d new_tag=%h old_tag=%h",
                         $time, raddr, fill_tag, tag_q[raddr]);
            if (do_write)
                $display("%0t tag_store write idx=%0d old_dirty=%0b",
                         $time, waddr, dirty_q[waddr]);
        end
    end
`else
`endif

endmodule

// File: tb/tb_tag_store.sv
// Scoreboard bench for tag_store: stimulus pushes expected read results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tag_store;

    localparam int LINES = 64;
    localparam int LSB   = 6;
    localparam int TSB   = 18;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [LSB-1:0] raddr = '0;
    logic           read_valid;
    logic           read_dirty;
    logic [TSB-1:0] read_tag;
    logic           do_fill = 1'b0;
    logic [TSB-1:0] fill_tag = '0;
    logic [LSB-1:0] waddr = '0;
    logic           do_write = 1'b0;

    tag_store dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .read_valid (read_valid),
        .read_dirty (read_dirty),
        .read_tag   (read_tag),
        .do_fill    (do_fill),
        .fill_tag   (fill_tag),
        .waddr      (waddr),
        .do_write   (do_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        bit           d;
        bit [TSB-1:0] t;
        int           id;
        int           idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the contents of the array as the spec defines them.
    bit           m_valid [LINES];
    bit           m_dirty [LINES];
    bit [TSB-1:0] m_tag   [LINES];

    // Drive one cycle of stimulus, record expected reads, then advance the model.
    task automatic step(input int r, input bit fill, input bit [TSB-1:0] ftag,
                        input int w, input bit wr, input bit rst, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        raddr    = LSB'(r);
        do_fill  = fill;
        fill_tag = ftag;
        waddr    = LSB'(w);
        do_write = wr;
        e.v   = rst ? 1'b0 : m_valid[r];
        e.d   = rst ? 1'b0 : m_dirty[r];
        e.t   = rst ? '0   : m_tag[r];
        e.id  = id;
        e.idx = r;
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
                m_tag[i]   = '0;
            end
        end else begin
            if (fill) begin
                m_valid[r] = 1'b1;
                m_tag[r]   = ftag;
                m_dirty[r] = 1'b0;
            end
            if (wr) m_dirty[w] = 1'b1;
        end
    endtask

    task automatic rd(input int r, input int id);
        step(r, 1'b0, '0, 0, 1'b0, 1'b0, id);
    endtask

    // Monitor: every cycle with a pending expectation, compare DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (read_valid !== e.v || read_dirty !== e.d || read_tag !== e.t) begin
                errors++;
                $display("FAIL check%0d idx=%0d got v=%b d=%b t=%h want v=%b d=%b t=%h",
                         e.id, e.idx, read_valid, read_dirty, read_tag, e.v, e.d, e.t);
            end
        end
    end

    initial begin
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        // Reset and sweep.
        step(0, 1'b0, '0, 0, 1'b0, 1'b1, 1);
        step(0, 1'b0, '0, 0, 1'b0, 1'b1, 1);
        for (int i = 0; i < LINES; i++) rd(i, 2);
        // Fill index 3, no bypass in the fill cycle, index 4 untouched.
        step(3, 1'b1, 18'h01234, 0, 1'b0, 1'b0, 3);
        rd(3, 4);
        rd(4, 5);
        // Write marks dirty; refill clears it.
        step(5, 1'b0, '0, 3, 1'b1, 1'b0, 6);
        rd(3, 7);
        step(3, 1'b1, 18'h00042, 0, 1'b0, 1'b0, 8);
        rd(3, 9);
        // Same-index fill+write, then different indices.
        step(7, 1'b1, 18'h3FFFF, 7, 1'b1, 1'b0, 10);
        rd(7, 11);
        step(7, 1'b1, 18'h3FFFF, 8, 1'b1, 1'b0, 12);
        rd(7, 13);
        rd(8, 14);
        // Boundary indices, then reset overriding a fill.
        step(0,  1'b1, 18'h00001, 0, 1'b0, 1'b0, 15);
        step(31, 1'b1, 18'h2AAAA, 0, 1'b0, 1'b0, 15);
        step(63, 1'b1, 18'h15555, 0, 1'b0, 1'b0, 15);
        rd(0, 16);
        rd(31, 16);
        rd(63, 16);
        step(10, 1'b1, 18'h0BEEF, 0, 1'b0, 1'b1, 17);
        for (int i = 0; i < LINES; i++) rd(i, 18);
        // Randomised traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            step(int'($urandom_range(0, LINES - 1)),
                 ($urandom_range(0, 2) == 0),
                 TSB'($urandom),
                 int'($urandom_range(0, LINES - 1)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 79) == 0),
                 100);
        end
        for (int i = 0; i < LINES; i++) rd(i, 101);
        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
